// File: rtl/ft232h_pkt_pkg.sv
// Shared types and framing constants for the FT232H TX packetizer and its host-side decoder model.
package ft232h_pkt_pkg;

  typedef enum logic [2:0] {
    StFill,
    StWaitSpace,
    StHdr,
    StPayload,
    StCsum
  } pkt_state_e;

  localparam logic [15:0] HDR_BYTES     = 16'd5;
  localparam logic [15:0] TRAILER_BYTES = 16'd1;
  localparam int unsigned FLAG_EOF      = 0;

  // Total bytes on the wire for a packet carrying payload_len bytes.
  function automatic logic [15:0] pkt_len(input logic [15:0] payload_len);
    return payload_len + HDR_BYTES + TRAILER_BYTES;
  endfunction

endpackage

// File: rtl/ft232h_tx_packetizer_if.sv
// Producer stream and driver-FIFO write port of the TX packetizer, bundled for port lists.
interface ft232h_tx_packetizer_if;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic        data_last_in;
  logic        data_ready_out;
  logic [15:0] remaining_space_in;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        busy_out;

  modport master (
    output data_in, data_valid_in, data_last_in, remaining_space_in,
    input  data_ready_out, tx_data_out, tx_valid_out, busy_out
  );

  modport slave (
    input  data_in, data_valid_in, data_last_in, remaining_space_in,
    output data_ready_out, tx_data_out, tx_valid_out, busy_out
  );
endinterface

// File: rtl/tx_payload_ram.sv
// Simple dual-port payload buffer: synchronous write, registered read with 1-cycle latency.
module tx_payload_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [Width-1:0]         rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ft232h_tx_packetizer.sv
// Buffers producer bytes into chunks and frames each as SYNC/seq/flags/len/payload/checksum,
// starting a packet only once the driver FIFO can absorb all of it.
module ft232h_tx_packetizer
  import ft232h_pkt_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD      = 256,
  parameter int unsigned IDLE_FLUSH_TICKS = 1024,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
  input logic                   clk_in,
  input logic                   reset_n_in,
  ft232h_tx_packetizer_if.slave bus
);

  localparam int unsigned AddrW = $clog2(MAX_PAYLOAD);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned IdleW = $clog2(IDLE_FLUSH_TICKS + 1);

  pkt_state_e       state_q;
  logic [CntW-1:0]  count_q, rd_ptr_q, count_inc;
  logic [7:0]       seq_q, sum_q, tx_data_q, flags, chk, ram_rdata;
  logic             eof_q, tx_valid_q, ready, accept, rd_en, idle_hit;
  logic [IdleW-1:0] idle_q;
  logic [2:0]       hdr_idx_q;
  logic [15:0]      len16;
  logic [AddrW-1:0] rd_addr;

  always_comb begin
    ready           = reset_n_in && (state_q == StFill) && (count_q < CntW'(MAX_PAYLOAD));
    accept          = bus.data_valid_in && ready;
    count_inc       = count_q + CntW'(1);
    len16           = 16'(count_q);
    flags           = 8'h00;
    flags[FLAG_EOF] = eof_q;
    chk             = 8'h00 - (seq_q + flags + len16[7:0] + len16[15:8] + sum_q);
    idle_hit        = (idle_q == IdleW'(IDLE_FLUSH_TICKS - 1));
    // Address 0 is fetched during the final header byte so payload byte 0 is ready on time.
    rd_en           = ((state_q == StHdr) && (hdr_idx_q == 3'd4)) || (state_q == StPayload);
    rd_addr         = (state_q == StPayload) ? rd_ptr_q[AddrW-1:0] : '0;
  end

  assign bus.data_ready_out = ready;
  assign bus.tx_valid_out   = tx_valid_q;
  assign bus.tx_data_out    = (state_q == StPayload) ? ram_rdata : tx_data_q;
  assign bus.busy_out       = (state_q != StFill) || (count_q != '0);

  tx_payload_ram #(
    .Depth (MAX_PAYLOAD),
    .Width (8)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (accept),
    .wr_addr (count_q[AddrW-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StFill;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      sum_q      <= '0;
      eof_q      <= 1'b0;
      idle_q     <= '0;
      hdr_idx_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            count_q <= count_inc;
            sum_q   <= sum_q + bus.data_in;
            idle_q  <= '0;
            if (bus.data_last_in) eof_q <= 1'b1;
            if (bus.data_last_in || (count_inc == CntW'(MAX_PAYLOAD))) state_q <= StWaitSpace;
          end else if (count_q != '0) begin
            if (idle_hit) begin
              idle_q  <= '0;
              state_q <= StWaitSpace;
            end else begin
              idle_q <= idle_q + IdleW'(1);
            end
          end
        end
        StWaitSpace: begin
          if (bus.remaining_space_in >= pkt_len(len16)) begin
            state_q    <= StHdr;
            hdr_idx_q  <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_BYTE;
          end
        end
        StHdr: begin
          hdr_idx_q <= hdr_idx_q + 3'd1;
          unique case (hdr_idx_q)
            3'd0:    tx_data_q <= seq_q;
            3'd1:    tx_data_q <= flags;
            3'd2:    tx_data_q <= len16[7:0];
            3'd3:    tx_data_q <= len16[15:8];
            default: begin
              state_q  <= StPayload;
              rd_ptr_q <= CntW'(1);
            end
          endcase
        end
        StPayload: begin
          if (rd_ptr_q == count_q) begin
            state_q   <= StCsum;
            tx_data_q <= chk;
          end else begin
            rd_ptr_q <= rd_ptr_q + CntW'(1);
          end
        end
        StCsum: begin
          state_q    <= StFill;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
          seq_q      <= seq_q + 8'd1;
          count_q    <= '0;
          eof_q      <= 1'b0;
          sum_q      <= '0;
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule
